// File: rtl/z80bd_intctl.sv
// Z80 board interrupt controller: merges the 16550 INTR with a periodic tick onto INT,
// supplies the IM2 vector during acknowledge and exposes one control/status I/O port.
module z80bd_intctl #(
  parameter int          TICK_DIV = 480000,
  parameter logic [7:0]  CTL_PORT = 8'h12,
  parameter logic [7:0]  VEC_BASE = 8'hE0
) (
  input  logic       CLK_24MHz,
  input  logic       RES,
  input  logic [7:0] A_LO,
  input  logic       IORQ,
  input  logic       M1,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  input  logic       U_INT,
  output logic       INT
);

  // state | meaning
  // IDLE  | INT follows the merged request; waiting for an acknowledge
  // ACK   | vector driven onto the bus, INT held high
  // DONE  | bus released; clears TPEND if the tick was acknowledged
  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [1:0] iorq_sy, m1_sy, rd_sy, wr_sy, uint_sy;
  logic       wr_prev;
  logic       iorq_s, m1_s, rd_s, wr_s, ureq;

  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      iorq_sy <= 2'b11;
      m1_sy   <= 2'b11;
      rd_sy   <= 2'b11;
      wr_sy   <= 2'b11;
      uint_sy <= 2'b00;
      wr_prev <= 1'b1;
    end else begin
      iorq_sy <= {iorq_sy[0], IORQ};
      m1_sy   <= {m1_sy[0], M1};
      rd_sy   <= {rd_sy[0], RD};
      wr_sy   <= {wr_sy[0], WR};
      uint_sy <= {uint_sy[0], U_INT};
      wr_prev <= wr_sy[1];
    end
  end

  assign iorq_s = iorq_sy[1];
  assign m1_s   = m1_sy[1];
  assign rd_s   = rd_sy[1];
  assign wr_s   = wr_sy[1];
  assign ureq   = uint_sy[1];

  logic io_sel, wr_stb, rd_act, ack_req;
  assign io_sel  = !iorq_s && m1_s && (A_LO == CTL_PORT);
  assign wr_stb  = io_sel && !wr_s && wr_prev;
  assign rd_act  = io_sel && !rd_s;
  assign ack_req = !m1_s && !iorq_s;

  logic [CW-1:0] cnt;
  logic          wrap;
  assign wrap = (cnt == CNT_MAX);

  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) cnt <= '0;
    else      cnt <= wrap ? '0 : cnt + CW'(1);
  end

  state_t     state, state_nxt;
  logic [2:0] winner, winner_nxt;
  logic       int_nxt;
  logic       uen, ten, tpend, ovr;
  logic       req_u, req_t, tick_set, done_clr;
  logic [7:0] status, vec;
  logic       rd_oe_q;
  logic [7:0] rd_data_q;
  logic       unused_din;

  assign unused_din = ^D_IN[6:2];
  assign req_u    = uen & ureq;
  assign req_t    = ten & tpend;
  assign tick_set = wrap & ten;
  assign done_clr = (state == DONE) && (winner == 3'd1);
  assign status   = {1'b0, ovr, tpend, ureq, 2'b00, ten, uen};
  assign vec      = VEC_BASE | {4'b0000, winner, 1'b0};

  // A wrap always beats a simultaneous clear, and leaves OVR out of the clear.
  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      uen   <= 1'b0;
      ten   <= 1'b0;
      tpend <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (wr_stb) {ten, uen} <= D_IN[1:0];
      if (tick_set) begin
        tpend <= 1'b1;
        ovr   <= ovr | tpend;
      end else if (wr_stb && D_IN[7]) begin
        tpend <= 1'b0;
        ovr   <= 1'b0;
      end else if (done_clr) begin
        tpend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      rd_oe_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      rd_oe_q   <= rd_act;
      rd_data_q <= rd_act ? status : 8'h00;
    end
  end

  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      state  <= IDLE;
      winner <= 3'd7;
      INT    <= 1'b1;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
      INT    <= int_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    int_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (ack_req) begin
          state_nxt  = ACK;
          winner_nxt = req_u ? 3'd0 : (req_t ? 3'd1 : 3'd7);
        end else begin
          int_nxt = ~(req_u | req_t);
        end
      end
      ACK:     if (m1_s || iorq_s) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign D_OE  = (state == ACK) | rd_oe_q;
  assign D_OUT = (state == ACK) ? vec : rd_data_q;

endmodule

// File: tb/tb_z80bd_intctl.sv
// Bench for z80bd_intctl with TICK_DIV=16: table-driven CTL/status vectors plus
// hand-written UART, tick, priority, collision, spurious and reset-in-ack sequences.
module tb_z80bd_intctl;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [7:0] a_lo = 8'h00;
  logic       iorq = 1'b1, m1 = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic       u_int = 1'b0;
  logic       int_n;

  int n_chk = 0;
  int n_fail = 0;
  int since_rst;

  typedef struct { string name; logic [7:0] val; } sb_t;
  sb_t sb_q[$];

  typedef struct { logic [7:0] wdata; logic uint; logic [7:0] status; logic int_n; } vec_t;
  vec_t tbl[8];

  z80bd_intctl #(.TICK_DIV(16), .CTL_PORT(8'h12), .VEC_BASE(8'hE0)) dut (
    .CLK_24MHz(clk), .RES(res), .A_LO(a_lo), .IORQ(iorq), .M1(m1), .RD(rd), .WR(wr),
    .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe), .U_INT(u_int), .INT(int_n)
  );

  always #21 clk = ~clk;

  // Posedges since reset release; the tick counter wraps on every 16th one.
  always @(posedge clk or negedge res) begin
    if (!res) since_rst <= 0;
    else      since_rst <= since_rst + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_push(input string nm, input logic [7:0] v);
    sb_t e;
    e.name = nm;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: got 0x%0h, expected an entry", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.val);
    end
  endtask

  task automatic bus_capture(input string tag);
    int lat = 0;
    while (!d_oe && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_oe_lat"}, lat, 3);
    sb_check(d_out);
  endtask

  task automatic bus_release(input string tag);
    int lat = 0;
    while (d_oe && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_off_lat"}, lat, 3);
  endtask

  task automatic io_write(input logic [7:0] d);
    a_lo = 8'h12; d_in = d; iorq = 1'b0; wr = 1'b0;
    cyc(4);
    iorq = 1'b1; wr = 1'b1;
    cyc(2);
  endtask

  task automatic io_read();
    a_lo = 8'h12; iorq = 1'b0; rd = 1'b0;
    bus_capture("rd");
    iorq = 1'b1; rd = 1'b1;
    bus_release("rd");
  endtask

  task automatic io_ack();
    m1 = 1'b0; iorq = 1'b0;
    bus_capture("ack");
    chk("ack_int_high", int_n, 1);
    m1 = 1'b1; iorq = 1'b1;
    bus_release("ack");
  endtask

  task automatic wait_int_low(input string nm, output int t);
    int k = 0;
    while (int_n && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (int_n) chk({nm, "_timeout"}, int_n, 0);
    t = since_rst;
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    while ((since_rst % 16) != p && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("phase_timeout", k, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;

    tbl[0] = '{8'h01, 1'b0, 8'h01, 1'b1};
    tbl[1] = '{8'h01, 1'b1, 8'h11, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 8'h10, 1'b1};
    tbl[3] = '{8'h7D, 1'b1, 8'h11, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 8'h10, 1'b1};
    tbl[5] = '{8'h81, 1'b1, 8'h11, 1'b0};
    tbl[6] = '{8'h01, 1'b0, 8'h01, 1'b1};
    tbl[7] = '{8'h00, 1'b0, 8'h00, 1'b1};

    // Reset held with random strobe activity
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iorq = 1'($urandom); m1 = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      a_lo = 8'h12; d_in = 8'hFF; u_int = 1'($urandom);
      #1;
      chk("rst_int", int_n, 1);
      chk("rst_oe", d_oe, 0);
    end
    @(negedge clk);
    iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1; u_int = 1'b0; d_in = 8'h00;
    cyc(3);
    res = 1'b1;
    cyc(3);
    sb_push("rst_status", 8'h00);
    io_read();

    for (int i = 0; i < 8; i++) begin
      u_int = tbl[i].uint;
      io_write(tbl[i].wdata);
      cyc(5);
      chk($sformatf("tbl%0d_int", i), int_n, tbl[i].int_n);
      sb_push($sformatf("tbl%0d_status", i), tbl[i].status);
      io_read();
    end

    // UART path with exact INT latency
    io_write(8'h01);
    u_int = 1'b1;
    cyc(2); chk("uart_int_lat2", int_n, 1);
    cyc(1); chk("uart_int_lat3", int_n, 0);
    sb_push("uart_vec", 8'hE0);
    io_ack();
    cyc(6); chk("uart_int_reassert", int_n, 0);
    u_int = 1'b0;
    cyc(2); chk("uart_drop_lat2", int_n, 0);
    cyc(1); chk("uart_drop_lat3", int_n, 1);

    // Spurious acknowledge
    io_write(8'h01);
    u_int = 1'b1;
    wait_int_low("spur", t1);
    u_int = 1'b0;
    cyc(1);
    sb_push("spur_vec", 8'hEE);
    io_ack();
    cyc(6); chk("spur_int_idle", int_n, 1);

    // Tick path
    io_write(8'h02);
    wait_int_low("tick1", t1);
    chk("tick1_phase", t1 % 16, 1);
    sb_push("tick_vec", 8'hE2);
    io_ack();
    sb_push("tick_status_clr", 8'h02);
    io_read();
    wait_int_low("tick2", t2);
    chk("tick_period", t2 - t1, 16);
    io_write(8'h80);
    cyc(4);
    chk("tick_off_int", int_n, 1);

    // Priority, overrun, clear, then clear colliding with a wrap
    io_write(8'h03);
    u_int = 1'b1;
    cyc(40);
    sb_push("prio_status", 8'h73);
    io_read();
    sb_push("prio_vec", 8'hE0);
    io_ack();
    wait_phase(1);
    io_write(8'h83);
    sb_push("prio_clr_status", 8'h13);
    io_read();
    wait_phase(2);
    sb_push("prio_tpend_status", 8'h33);
    io_read();
    wait_phase(13);
    io_write(8'h83);
    sb_push("collide_status", 8'h73);
    io_read();
    u_int = 1'b0;
    wait_phase(1);
    io_write(8'h80);
    cyc(4);

    // Reset during ACK
    io_write(8'h01);
    u_int = 1'b1;
    wait_int_low("rstack", t1);
    m1 = 1'b0; iorq = 1'b0;
    cyc(4);
    chk("rstack_in_ack", d_oe, 1);
    #5 res = 1'b0;
    #1;
    chk("rstack_oe", d_oe, 0);
    chk("rstack_int", int_n, 1);
    chk("rstack_dout", d_out, 8'h00);
    m1 = 1'b1; iorq = 1'b1; u_int = 1'b0;
    cyc(2);
    res = 1'b1;
    io_write(8'h02);
    wait_int_low("rstack_tick", t1);
    chk("rstack_first_tick", t1, 17);

    if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
